// File: rtl/spi_master_shift.sv
// SPI mode-0 master paced by the /32 divider output; one word per start pulse, full duplex.
// Build option: define SPI_LSB_FIRST_EN to shift LSB-first in both directions (default MSB-first).
module spi_master_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_32,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] tx_shift, tx_shift_d;
    logic [DATA_W-1:0] rx_shift, rx_shift_d;
    logic [DATA_W-1:0] rx_data_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic              clk_32_q;
    logic              busy_d, done_d, sclk_d, mosi_d, cs_n_d;
    logic              rise, fall;

    // clk_32 is a counter bit in this clock domain, so a single delay stage gives clean edges
    assign rise = clk_32 & ~clk_32_q;
    assign fall = ~clk_32 & clk_32_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clk_32_q <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            state    <= state_d;
            clk_32_q <= clk_32;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            bit_cnt  <= bit_cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            cs_n     <= cs_n_d;
        end
    end

    always_comb begin
        state_d    = state;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        bit_cnt_d  = bit_cnt;
        busy_d     = busy;
        done_d     = 1'b0;
        sclk_d     = sclk;
        mosi_d     = mosi;
        cs_n_d     = cs_n;

        case (state)
            IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = CNT_W'(DATA_W);
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
`ifdef SPI_LSB_FIRST_EN
                    mosi_d     = tx_data[0];
`else
                    mosi_d     = tx_data[DATA_W-1];
`endif
                    state_d    = LEAD;
                end
            end
            LEAD: begin
                if (fall) state_d = SHIFT;
            end
            SHIFT: begin
                if (rise) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt - CNT_W'(1);
`ifdef SPI_LSB_FIRST_EN
                    rx_shift_d = {miso, rx_shift[DATA_W-1:1]};
`else
                    rx_shift_d = {rx_shift[DATA_W-2:0], miso};
`endif
                end else if (fall) begin
                    sclk_d = 1'b0;
                    if (bit_cnt == '0) begin
                        state_d = TRAIL;
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        tx_shift_d = tx_shift >> 1;
                        mosi_d     = tx_shift[1];
`else
                        tx_shift_d = tx_shift << 1;
                        mosi_d     = tx_shift[DATA_W-2];
`endif
                    end
                end
            end
            TRAIL: begin
                // hold CS low for half an SCLK period after the last falling edge
                if (rise) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_shift;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_shift.sv
// Directed self-checking bench for spi_master_shift (DATA_W=8) with a free-running /32 divider model.
// Expected MOSI order follows SPI_LSB_FIRST_EN when that macro is defined.
module tb_spi_master_shift;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_32;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic [7:0] rx_data;
    logic       busy, done, sclk, mosi, cs_n;

    logic [4:0] div_cnt = 5'd0;
    bit         loop_en = 1'b1;
    logic       miso_const = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int         cyc = 0;
    int         rise_total = 0;
    int         done_total = 0;
    int         sclk_period = 0;
    int         last_rise = -1;
    int         rise_base = 0;
    logic       sclk_prev = 1'b0;
    logic [7:0] mosi_seq = 8'h00;

    spi_master_shift #(.DATA_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_32  (clk_32),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs_n    (cs_n)
    );

    always #5 clk = ~clk;

    // divider model: toggles away from the active edge so clk_32 never races the DUT
    always @(negedge clk) div_cnt = div_cnt + 5'd1;
    assign clk_32 = div_cnt[4];
    assign miso   = loop_en ? mosi : miso_const;

    // bus monitor: counts SCLK rises under CS, collects MOSI at each rise, measures period
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sclk && !sclk_prev && !cs_n) begin
            rise_total = rise_total + 1;
            mosi_seq   = {mosi_seq[6:0], mosi};
            if (last_rise >= 0) sclk_period = cyc - last_rise;
            last_rise = cyc;
        end
        sclk_prev = sclk;
        if (done) done_total = done_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] expSeq(input logic [7:0] tx);
        logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = tx[7-i];
`else
        r = tx;
`endif
        return r;
    endfunction

    task automatic applyStimulus(input logic [7:0] tx);
        @(negedge clk);
        start     = 1'b1;
        tx_data   = tx;
        rise_base = rise_total;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx,
                            input bit chain, input logic [7:0] next_tx);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
            checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            checkOutput({tag, "_cs_n_at_done"}, 32'(cs_n), 32'd1);
            checkOutput({tag, "_sclk_rises"}, 32'(rise_total - rise_base), 32'd8);
            checkOutput({tag, "_mosi_seq"}, 32'(mosi_seq), 32'(expSeq(tx)));
            checkOutput({tag, "_sclk_period"}, 32'(sclk_period), 32'd32);
            if (chain) begin
                start     = 1'b1;
                tx_data   = next_tx;
                rise_base = rise_total;
            end
            @(negedge clk);
            start = 1'b0;
            checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
            checkOutput({tag, "_busy_after"}, 32'(busy), 32'(chain));
        end
    endtask

    initial begin
        int  done_snap;
        bit  reached;
        bit  idle_bad;

        $display("[TB] start");
        repeat (5) @(negedge clk);
        checkOutput("reset_cs_n", 32'(cs_n), 32'd1);
        checkOutput("reset_sclk", 32'(sclk), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_cs_n", 32'(cs_n), 32'd1);
        checkOutput("idle_sclk", 32'(sclk), 32'd0);
        checkOutput("idle_mosi", 32'(mosi), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_rx_data", 32'(rx_data), 32'd0);
        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || rx_data !== 8'h00) idle_bad = 1'b1;
        end
        checkOutput("idle_stable", 32'(idle_bad), 32'd0);

        $display("[TB] loopback 0xA5");
        loop_en = 1'b1;
        applyStimulus(8'hA5);
        waitDone("loop_a5", 8'hA5, 8'hA5, 1'b0, 8'h00);

        $display("[TB] constant miso");
        loop_en    = 1'b0;
        miso_const = 1'b1;
        applyStimulus(8'h00);
        waitDone("miso1", 8'h00, 8'hFF, 1'b0, 8'h00);
        miso_const = 1'b0;
        applyStimulus(8'hFF);
        waitDone("miso0", 8'hFF, 8'h00, 1'b0, 8'h00);

        $display("[TB] busy start and back-to-back");
        loop_en = 1'b1;
        applyStimulus(8'h5A);
        repeat (60) @(negedge clk);
        checkOutput("busy_mid", 32'(busy), 32'd1);
        start   = 1'b1;
        tx_data = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        waitDone("busy_5a", 8'h5A, 8'h5A, 1'b1, 8'hC3);
        waitDone("b2b_c3", 8'hC3, 8'hC3, 1'b0, 8'h00);

        $display("[TB] reset mid-transfer");
        applyStimulus(8'h96);
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            @(negedge clk);
            if (rise_total - rise_base >= 4) reached = 1'b1;
        end
        checkOutput("mid_reached_4_rises", 32'(reached), 32'd1);
        done_snap = done_total;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_reset_cs_n", 32'(cs_n), 32'd1);
        checkOutput("mid_reset_sclk", 32'(sclk), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("mid_reset_no_done", 32'(done_total - done_snap), 32'd0);
        applyStimulus(8'h81);
        waitDone("after_reset_81", 8'h81, 8'h81, 1'b0, 8'h00);

        $display("[TB] loopback 0x01");
        applyStimulus(8'h01);
        waitDone("loop_01", 8'h01, 8'h01, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_shift.md
Name: spi_master_shift

Overview:
- Serial SPI master (mode 0: CPOL=0, CPHA=0) that sits directly downstream of the /32 clock-divider stage.
- Consumes the divider's clk_32 square wave and uses its edges to pace SCLK, MOSI shifting and MISO sampling.
- Accepts one parallel word per start pulse, runs a chip-select-framed full-duplex transfer, and returns the received word with a one-cycle done pulse.

Parameters:
- DATA_W, 8, transfer word width in bits (valid range 2..32).

Ports:
- clk  input  1  system clock; the same clock that drives the divider.
- reset  input  1  asynchronous, active-high reset.
- clk_32  input  1  divided clock from the divider stage. It is a counter bit in the clk domain, so it needs no synchronizer.
- start  input  1  transfer request, sampled on clk. Accepted only in IDLE.
- tx_data  input  DATA_W  word to transmit, latched on the accepting cycle.
- miso  input  1  serial data from the slave.
- rx_data  output  DATA_W  last received word. Updated in the same cycle done is asserted.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- sclk  output  1  SPI clock, registered, idle low.
- mosi  output  1  serial data to the slave, registered.
- cs_n  output  1  active-low chip select, registered.

Behaviour:
- Clock and reset: single clock domain, all state on posedge clk. Reset is asynchronous and active-high. During reset:
  - cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - The FSM returns to IDLE and the internal clk_32 delay register clears to 0.
- Edge detection:
  - clk_32_q is clk_32 registered once.
  - rise = clk_32 & ~clk_32_q.
  - fall = ~clk_32 & clk_32_q.
  - Each event lasts exactly one clk cycle. Rise and fall never occur in the same cycle.
- IDLE: cs_n=1, sclk=0, busy=0.
  - On start=1: latch tx_data into tx_shift, clear rx_shift, load bit_cnt=DATA_W.
  - Next cycle: cs_n=0, mosi=tx_shift MSB, busy=1, state LEAD.
- LEAD: hold. On the first fall event go to SHIFT. This gives at least a half clk_32 period (16 clk cycles) of CS and MOSI setup before the first SCLK rise.
- SHIFT:
  - On rise: sclk<=1, rx_shift<={rx_shift[DATA_W-2:0], miso}, bit_cnt<=bit_cnt-1.
  - On fall: sclk<=0. If bit_cnt==0 go to TRAIL; otherwise shift tx_shift left and drive the new MSB on mosi.
- TRAIL: sclk stays 0. On the next rise event go to IDLE, and in that same cycle:
  - cs_n<=1, busy<=0, mosi<=0;
  - rx_data<=rx_shift, done<=1.
- done timing: done is high for exactly one cycle, the first cycle back in IDLE. A start in that cycle is accepted (back-to-back transfers).
- Busy start: start while busy=1 is ignored, with no queuing and no effect on the current transfer.
- Timing: SCLK period equals the clk_32 period (32 clk cycles). SCLK lags clk_32 by one clk cycle. MISO is sampled one clk after the clk_32 rise, together with the SCLK rise.
- Latency from the start cycle to done:
  - LEAD wait of 1..32 cycles, depending on clk_32 phase;
  - plus DATA_W×32;
  - plus 16;
  - plus a few fixed cycles.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). The partial rx word is discarded and no done is generated.
- clk_32 stuck (divider held in reset): the FSM waits indefinitely in its current state. No timeout.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined:
  - tx_shift shifts right and mosi drives tx_shift[0];
  - rx_shift shifts in from the MSB side, rx_shift<={miso, rx_shift[DATA_W-1:1]}.
  - Result: LSB-first on both directions.
- Undefined: MSB-first as specified above. Port list and timing are identical in both builds.

Test Plan:
- Reset and idle: hold reset for 5 cycles, then release with no start. Required: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and outputs stay at these values for 100 cycles.
- Loopback: tie miso=mosi, start with tx_data=0xA5 (DATA_W=8). Required:
  - exactly 8 sclk rising edges while cs_n=0;
  - mosi sequence 1,0,1,0,0,1,0,1;
  - one-cycle done with rx_data=0xA5, and busy falls in the same cycle.
- Constant MISO: drive miso=1, send 0x00; then miso=0, send 0xFF. Required: rx_data=0xFF, then rx_data=0x00. The sclk period measures 32 clk cycles high-to-high.
- Busy start ignored and back-to-back:
  - pulse start with 0x3C during a transfer of 0x5A: only 0x5A is transmitted;
  - start with 0xC3 in the done cycle: second transfer begins and transmits 0xC3.
- Reset mid-transfer: assert reset after 4 sclk rises. Required: cs_n=1, sclk=0, busy=0 immediately, no done pulse, and a following transfer of 0x81 completes correctly.
- SPI_LSB_FIRST_EN build with loopback and tx_data=0x01. Required: first mosi bit 1, then seven 0s, and rx_data=0x01.
